// File: rtl/knn_topk.sv
// knn_topk: squares the packed {dx,dy} lane-difference word and keeps the
// K smallest squared distances (with sample index tags) in a sorted list
// readable through a combinational select port.
// Optional build macro KNN_TOPK_STATS_EN adds the n_seen/n_drop counters.
module knn_topk #(
  parameter int K     = 4,
  parameter int IDX_W = 8,
  parameter int SEL_W = $clog2(K),
  parameter int CNT_W = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [31:0]      in_dist,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [SEL_W-1:0] rd_sel,
  output logic             rd_vld,
  output logic [31:0]      rd_dist,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] count,
`ifdef KNN_TOPK_STATS_EN
  output logic [15:0]      n_seen,
  output logic [15:0]      n_drop,
`endif
  output logic             busy
);

  logic flush;
  assign flush = rst | clear;

  // Stage 1: square both signed lanes; the sum peaks at 2^31 so 32 bits suffice
  logic signed [15:0] dx, dy;
  logic signed [31:0] dx2, dy2;
  logic [31:0]        sq_d;
  assign dx   = in_dist[31:16];
  assign dy   = in_dist[15:0];
  assign dx2  = dx * dx;
  assign dy2  = dy * dy;
  assign sq_d = $unsigned(dx2) + $unsigned(dy2);

  logic             s1_vld_q;
  logic [31:0]      s1_sq_q;
  logic [IDX_W-1:0] s1_idx_q;

  // Stage-1 register: capture squared distance and tag of an accepted sample
  always_ff @(posedge clk) begin
    if (flush) begin
      s1_vld_q <= 1'b0;
      s1_sq_q  <= '0;
      s1_idx_q <= '0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sq_q  <= sq_d;
        s1_idx_q <= in_idx;
      end
    end
  end

  // Sorted list storage; invalid entries always hold zero dist/idx
  logic             vld_q  [K];
  logic [31:0]      dist_q [K];
  logic [IDX_W-1:0] idx_q  [K];
  logic             vld_d  [K];
  logic [31:0]      dist_d [K];
  logic [IDX_W-1:0] idx_d  [K];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pos;
  logic             ins;

  // Stage 2: find insertion point (ties go after existing entries) and shift
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (vld_q[i] && (dist_q[i] <= s1_sq_q)) pos = pos + CNT_W'(1);
    end
    ins     = s1_vld_q && (pos < CNT_W'(K));
    count_d = count_q;
    for (int unsigned i = 0; i < K; i++) begin
      vld_d[i]  = vld_q[i];
      dist_d[i] = dist_q[i];
      idx_d[i]  = idx_q[i];
    end
    if (ins) begin
      // shift everything at or beyond the insertion point down by one;
      // the old last entry falls off the end
      for (int unsigned i = 1; i < K; i++) begin
        if (CNT_W'(i) > pos) begin
          vld_d[i]  = vld_q[i-1];
          dist_d[i] = dist_q[i-1];
          idx_d[i]  = idx_q[i-1];
        end
      end
      for (int unsigned i = 0; i < K; i++) begin
        if (CNT_W'(i) == pos) begin
          vld_d[i]  = 1'b1;
          dist_d[i] = s1_sq_q;
          idx_d[i]  = s1_idx_q;
        end
      end
      if (count_q < CNT_W'(K)) count_d = count_q + CNT_W'(1);
    end
  end

  // List and occupancy registers
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < K; i++) begin
        vld_q[i]  <= 1'b0;
        dist_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < K; i++) begin
        vld_q[i]  <= vld_d[i];
        dist_q[i] <= dist_d[i];
        idx_q[i]  <= idx_d[i];
      end
      count_q <= count_d;
    end
  end

`ifdef KNN_TOPK_STATS_EN
  logic [15:0] n_seen_q, n_drop_q;

  // Statistics: samples reaching stage 2 and samples rejected as too far
  always_ff @(posedge clk) begin
    if (flush) begin
      n_seen_q <= '0;
      n_drop_q <= '0;
    end else if (s1_vld_q) begin
      n_seen_q <= n_seen_q + 16'd1;
      if (!ins) n_drop_q <= n_drop_q + 16'd1;
    end
  end

  assign n_seen = n_seen_q;
  assign n_drop = n_drop_q;
`endif

  // Read mux; out-of-range selects fall through to zeros
  always_comb begin
    rd_vld  = 1'b0;
    rd_dist = '0;
    rd_idx  = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (rd_sel == SEL_W'(i) && vld_q[i]) begin
        rd_vld  = 1'b1;
        rd_dist = dist_q[i];
        rd_idx  = idx_q[i];
      end
    end
  end

  assign count = count_q;
  assign busy  = s1_vld_q;

endmodule

// File: tb/tb_knn_topk.sv
// Scoreboard bench for knn_topk: a queue-based reference list predicts the
// full list after every sample; snapshots are compared once the sample lands.
module tb_knn_topk;
  localparam int K     = 4;
  localparam int IDX_W = 8;
  localparam int SEL_W = 2;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst, clear, in_valid;
  logic [31:0]      in_dist;
  logic [IDX_W-1:0] in_idx;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_vld;
  logic [31:0]      rd_dist;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] count;
  logic             busy;
`ifdef KNN_TOPK_STATS_EN
  logic [15:0]      n_seen, n_drop;
`endif

  knn_topk #(.K(K), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_dist(in_dist), .in_idx(in_idx), .rd_sel(rd_sel),
    .rd_vld(rd_vld), .rd_dist(rd_dist), .rd_idx(rd_idx), .count(count),
`ifdef KNN_TOPK_STATS_EN
    .n_seen(n_seen), .n_drop(n_drop),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  i;
  } ent_t;

  typedef struct packed {
    logic [K-1:0][31:0] d;
    logic [K-1:0][7:0]  ix;
    logic [K-1:0]       v;
    logic [CNT_W-1:0]   cnt;
    logic               drop;
  } snap_t;

  ent_t  model[$];
  snap_t sbq[$];
  int    total = 0;
  int    bad   = 0;
  bit    pipe1 = 0, pipe2 = 0;
  int    m_seen = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t take_snap(input bit drop);
    snap_t s;
    s = '0;
    for (int n = 0; n < model.size(); n++) begin
      s.d[n]  = model[n].d;
      s.ix[n] = model[n].i;
      s.v[n]  = 1'b1;
    end
    s.cnt  = CNT_W'(model.size());
    s.drop = drop;
    return s;
  endfunction

  task automatic check_snap(input snap_t s, input string tag);
    for (int n = 0; n < K; n++) begin
      rd_sel = SEL_W'(n);
      #1;
      chk($sformatf("%s_vld%0d", tag, n), rd_vld, s.v[n]);
      chk($sformatf("%s_dist%0d", tag, n), rd_dist, s.d[n]);
      chk($sformatf("%s_idx%0d", tag, n), rd_idx, s.ix[n]);
    end
    chk({tag, "_count"}, count, s.cnt);
  endtask

  task automatic read_at(input int sel, input logic [31:0] d, input logic [7:0] ix, input string tag);
    rd_sel = SEL_W'(sel);
    #1;
    chk({tag, "_vld"}, rd_vld, 1);
    chk({tag, "_dist"}, rd_dist, d);
    chk({tag, "_idx"}, rd_idx, ix);
  endtask

  // One clock: track the bench's view of the pipeline, check busy and any
  // list update that lands on this edge
  task automatic tick();
    bit fl, acc;
    fl  = rst || clear;
    acc = in_valid && !fl;
    @(posedge clk);
    if (fl) begin
      pipe1 = 0;
      pipe2 = 0;
      sbq.delete();
      model.delete();
      m_seen = 0;
      m_drop = 0;
    end else begin
      pipe2 = pipe1;
      pipe1 = acc;
    end
    #1;
    chk("busy", busy, pipe1);
    if (pipe2) begin
      snap_t s;
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        s = sbq.pop_front();
        m_seen++;
        if (s.drop) m_drop++;
        check_snap(s, "list");
`ifdef KNN_TOPK_STATS_EN
        chk("n_seen", n_seen, m_seen);
        chk("n_drop", n_drop, m_drop);
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] dx, input logic [15:0] dy, input logic [7:0] ix);
    longint sx, sy, sq;
    logic [31:0] sq32;
    int pos;
    bit drop;
    ent_t e;
    sx   = longint'($signed(dx));
    sy   = longint'($signed(dy));
    sq   = sx * sx + sy * sy;
    sq32 = sq[31:0];
    pos  = 0;
    while (pos < model.size() && model[pos].d <= sq32) pos++;
    drop = (pos >= K);
    if (!drop) begin
      e.d = sq32;
      e.i = ix;
      model.insert(pos, e);
      if (model.size() > K) void'(model.pop_back());
    end
    sbq.push_back(take_snap(drop));
    in_valid = 1'b1;
    in_dist  = {dx, dy};
    in_idx   = ix;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_dist = '0; in_idx = '0; rd_sel = '0;
    tick(); tick();
    rst = 1'b0;
    check_snap(take_snap(0), "reset");

    // single sample: 3^2+4^2
    send(16'd3, 16'd4, 8'd7);
    idle(1);
    read_at(0, 32'd25, 8'd7, "single");
    idle(1);

    // negative lanes and extremes
    do_clear();
    send(16'hFFFD, 16'h0004, 8'd1);
    send(16'h8000, 16'h8000, 8'd2);
    send(16'h0000, 16'h0000, 8'd3);
    idle(2);
    read_at(0, 32'd0, 8'd3, "zero");
    read_at(1, 32'd25, 8'd1, "neg");
    read_at(2, 32'h80000000, 8'd2, "max");

    // back-to-back stream: 100,50,74,50,10,200
    do_clear();
    send(16'd10, 16'd0, 8'd1);
    send(16'd5, 16'd5, 8'd2);
    send(16'd7, 16'd5, 8'd3);
    send(16'd1, 16'd7, 8'd4);
    send(16'd3, 16'd1, 8'd5);
    send(16'd10, 16'd10, 8'd6);
    idle(2);
    read_at(0, 32'd10, 8'd5, "b2b0");
    read_at(1, 32'd50, 8'd2, "b2b1");
    read_at(2, 32'd50, 8'd4, "b2b2");
    read_at(3, 32'd74, 8'd3, "b2b3");
    chk("b2b_count", count, 4);
`ifdef KNN_TOPK_STATS_EN
    chk("b2b_seen", n_seen, 6);
    chk("b2b_drop", n_drop, 1);
`endif

    // clear together with a new sample while another is in stage 1
    send(16'd5, 16'd5, 8'd9);
    clear = 1'b1; in_valid = 1'b1; in_dist = {16'd1, 16'd1}; in_idx = 8'd30;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_snap(take_snap(0), "clr");
    idle(2);
    check_snap(take_snap(0), "clr_hold");
    send(16'd3, 16'd4, 8'd8);
    idle(1);
    read_at(0, 32'd25, 8'd8, "after_clr");

    // ties: four entries of 20, a fifth 20 drops, then 18 evicts the last
    do_clear();
    send(16'd4, 16'd2, 8'd10);
    send(16'd2, 16'd4, 8'd11);
    send(16'hFFFC, 16'd2, 8'd12);
    send(16'd2, 16'hFFFC, 8'd13);
    send(16'd4, 16'hFFFE, 8'd14);
    idle(2);
    read_at(0, 32'd20, 8'd10, "tie0");
    read_at(3, 32'd20, 8'd13, "tie3");
    chk("tie_count", count, 4);
    send(16'd3, 16'd3, 8'd15);
    idle(2);
    read_at(0, 32'd18, 8'd15, "evict0");
    read_at(3, 32'd20, 8'd12, "evict3");

    // reset mid-stream drops the in-flight sample
    send(16'd1, 16'd0, 8'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    check_snap(take_snap(0), "rst_mid");
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
